// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants, ID-stage FSM states and register-use helpers.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} id_state_t;

    // Opcodes that read rs1
    function automatic logic uses_rs1(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_OP: return 1'b1;
            default:                                              return 1'b0;
        endcase
    endfunction

    // Opcodes that read rs2
    function automatic logic uses_rs2(input logic [6:0] op);
        case (op)
            OP_STORE, OP_BRANCH, OP_OP: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_imm_ext.sv
// Combinational immediate extraction for all RV32I formats; sign bit is always inst[31].
module id_imm_ext
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    output logic [XLEN-1:0] imm_o
);

    // Select the immediate layout by opcode; unknown opcodes yield zero
    always_comb begin
        imm_o = '0;
        case (inst_i[6:0])
            OP_LOAD, OP_IMM, OP_JALR:
                imm_o = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
            OP_STORE:
                imm_o = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            OP_BRANCH:
                imm_o = {{(XLEN-13){inst_i[31]}}, inst_i[31], inst_i[7],
                         inst_i[30:25], inst_i[11:8], 1'b0};
            OP_JAL:
                imm_o = {{(XLEN-21){inst_i[31]}}, inst_i[31], inst_i[19:12],
                         inst_i[20], inst_i[30:21], 1'b0};
            OP_LUI, OP_AUIPC:
                imm_o = {{(XLEN-31){inst_i[31]}}, inst_i[30:12], 12'b0};
            default:
                imm_o = '0;
        endcase
    end

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage sequencer: IF/ID and ID/EX registers, load-use bubbles,
// branch flushes, memory freeze and saturating stall/flush counters.
module id_stage_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_valid,
    input  logic [31:0]      if_inst,
    input  logic [XLEN-1:0]  if_pc,
    input  logic             mem_busy,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             idex_valid,
    output logic [31:0]      idex_inst,
    output logic [XLEN-1:0]  idex_pc,
    output logic [XLEN-1:0]  idex_imm,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state
);

    id_state_t        state_q;
    logic             ifid_valid_q;
    logic [31:0]      ifid_inst_q;
    logic [XLEN-1:0]  ifid_pc_q;
    logic             idex_valid_q;
    logic [31:0]      idex_inst_q;
    logic [XLEN-1:0]  idex_pc_q;
    logic [XLEN-1:0]  idex_imm_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [XLEN-1:0]  ifid_imm;
    logic             hz;

    id_imm_ext #(.XLEN(XLEN)) u_imm (
        .inst_i (ifid_inst_q),
        .imm_o  (ifid_imm)
    );

    // Load-use hazard: the instruction in ID reads the register a load in EX is writing
    always_comb begin
        hz = ifid_valid_q && idex_valid_q && (idex_inst_q[6:0] == OP_LOAD)
             && (idex_inst_q[11:7] != 5'd0)
             && ((uses_rs1(ifid_inst_q[6:0]) && (ifid_inst_q[19:15] == idex_inst_q[11:7]))
              || (uses_rs2(ifid_inst_q[6:0]) && (ifid_inst_q[24:20] == idex_inst_q[11:7])));
    end

    // Saturating increments: counters stick at all-ones
    always_comb begin
        stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
        flush_cnt_d = (&flush_cnt_q) ? flush_cnt_q : flush_cnt_q + CNT_W'(1);
    end

    // A pending taken branch overrides the hazard hold, since IF/ID is being discarded anyway
    assign pc_write = !mem_busy && !((state_q == RUN) && hz && !ex_branch_taken);

    // Sequencer: freeze > branch flush > load-use bubble > FLUSH bubble > normal advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            ifid_valid_q <= 1'b0;
            ifid_inst_q  <= NOP_INST;
            ifid_pc_q    <= '0;
            idex_valid_q <= 1'b0;
            idex_inst_q  <= NOP_INST;
            idex_pc_q    <= '0;
            idex_imm_q   <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else if (!mem_busy) begin
            if (ex_branch_taken) begin
                ifid_valid_q <= 1'b0;
                idex_valid_q <= 1'b0;
                idex_inst_q  <= NOP_INST;
                idex_pc_q    <= '0;
                idex_imm_q   <= '0;
                flush_cnt_q  <= flush_cnt_d;
                state_q      <= FLUSH;
            end else if ((state_q == RUN) && hz) begin
                idex_valid_q <= 1'b0;
                idex_inst_q  <= NOP_INST;
                idex_pc_q    <= '0;
                idex_imm_q   <= '0;
                stall_cnt_q  <= stall_cnt_d;
                state_q      <= STALL;
            end else if (state_q == FLUSH) begin
                // Fetch still holds a wrong-path instruction: drop it
                ifid_valid_q <= 1'b0;
                idex_valid_q <= 1'b0;
                idex_inst_q  <= NOP_INST;
                idex_pc_q    <= '0;
                idex_imm_q   <= '0;
                state_q      <= RUN;
            end else begin
                idex_valid_q <= ifid_valid_q;
                idex_inst_q  <= ifid_inst_q;
                idex_pc_q    <= ifid_pc_q;
                idex_imm_q   <= ifid_imm;
                ifid_valid_q <= if_valid;
                if (if_valid) begin
                    ifid_inst_q <= if_inst;
                    ifid_pc_q   <= if_pc;
                end
                state_q      <= RUN;
            end
        end
    end

    assign idex_valid = idex_valid_q;
    assign idex_inst  = idex_inst_q;
    assign idex_pc    = idex_pc_q;
    assign idex_imm   = idex_imm_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign state      = state_q;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Bench for id_stage_ctrl: directed scenarios plus randomized traffic vs a behavioural model.
module tb_id_stage_ctrl;
    import riscv_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             if_valid;
    logic [31:0]      if_inst;
    logic [XLEN-1:0]  if_pc;
    logic             mem_busy;
    logic             ex_branch_taken;
    logic             pc_write;
    logic             idex_valid;
    logic [31:0]      idex_inst;
    logic [XLEN-1:0]  idex_pc;
    logic [XLEN-1:0]  idex_imm;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [1:0]       state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stage_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .mem_busy(mem_busy), .ex_branch_taken(ex_branch_taken), .pc_write(pc_write),
        .idex_valid(idex_valid), .idex_inst(idex_inst), .idex_pc(idex_pc), .idex_imm(idex_imm),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
    );

    // ---------------- behavioural reference model ----------------
    typedef struct {
        bit          v;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
    } stg_t;

    stg_t m_ifid, m_idex;
    int   m_mode;   // 0 run, 1 stall, 2 flush
    int   m_stall, m_flush;

    // Immediate via arithmetic shift of the field placed at the top of a word
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        logic signed [31:0] t;
        case (i[6:0])
            7'h03, 7'h13, 7'h67: begin t = {i[31:20], 20'b0}; return t >>> 20; end
            7'h23: begin t = {i[31:25], i[11:7], 20'b0}; return t >>> 20; end
            7'h63: begin t = {i[31], i[7], i[30:25], i[11:8], 20'b0}; return t >>> 19; end
            7'h6F: begin t = {i[31], i[19:12], i[20], i[30:21], 12'b0}; return t >>> 11; end
            7'h37, 7'h17: return {i[31:12], 12'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_hz();
        logic [6:0] op;
        logic [4:0] rd;
        bit r1, r2;
        op = m_ifid.inst[6:0];
        rd = m_idex.inst[11:7];
        r1 = op inside {7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h33};
        r2 = op inside {7'h23, 7'h63, 7'h33};
        return m_ifid.v && m_idex.v && (m_idex.inst[6:0] == 7'h03) && (rd != 0)
               && ((r1 && m_ifid.inst[19:15] == rd) || (r2 && m_ifid.inst[24:20] == rd));
    endfunction

    function automatic bit m_pcw(input bit busy, input bit bt);
        return !busy && !(m_mode == 0 && m_hz() && !bt);
    endfunction

    function automatic void m_reset();
        m_ifid  = '{1'b0, NOP_INST, 32'h0, 32'h0};
        m_idex  = '{1'b0, NOP_INST, 32'h0, 32'h0};
        m_mode  = 0;
        m_stall = 0;
        m_flush = 0;
    endfunction

    function automatic void m_step(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                                   input bit busy, input bit bt);
        if (busy) return;
        if (bt) begin
            m_ifid.v = 1'b0;
            m_idex   = '{1'b0, NOP_INST, 32'h0, 32'h0};
            if (m_flush < SAT) m_flush++;
            m_mode = 2;
        end else if (m_mode == 0 && m_hz()) begin
            m_idex = '{1'b0, NOP_INST, 32'h0, 32'h0};
            if (m_stall < SAT) m_stall++;
            m_mode = 1;
        end else if (m_mode == 2) begin
            m_ifid.v = 1'b0;
            m_idex   = '{1'b0, NOP_INST, 32'h0, 32'h0};
            m_mode   = 0;
        end else begin
            m_idex = '{m_ifid.v, m_ifid.inst, m_ifid.pc, ref_imm(m_ifid.inst)};
            if (v) m_ifid = '{1'b1, inst, pc, 32'h0};
            else   m_ifid.v = 1'b0;
            m_mode = 0;
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                         input bit busy, input bit bt);
        if_valid        = v;
        if_inst         = inst;
        if_pc           = pc;
        mem_busy        = busy;
        ex_branch_taken = bt;
    endtask

    task automatic edge_step();
        m_step(if_valid, if_inst, if_pc, mem_busy, ex_branch_taken);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, NOP_INST, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
    endtask

    function automatic logic [31:0] gen_inst();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 9);
        case (k)
            0: r[6:0] = 7'h03; 1: r[6:0] = 7'h13; 2: r[6:0] = 7'h23; 3: r[6:0] = 7'h63;
            4: r[6:0] = 7'h33; 5: r[6:0] = 7'h6F; 6: r[6:0] = 7'h67; 7: r[6:0] = 7'h37;
            8: r[6:0] = 7'h17; default: ;
        endcase
        r[11:7]  = 5'($urandom_range(0, 3));
        r[19:15] = 5'($urandom_range(0, 3));
        r[24:20] = 5'($urandom_range(0, 3));
        return r;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, NOP_INST, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (idex_valid !== 1'b0 || idex_inst !== NOP_INST || idex_pc !== 32'h0 || idex_imm !== 32'h0) begin
            errors++;
            $display("FAIL reset_idex got v=%0b inst=%h pc=%h imm=%h exp v=0 inst=%h pc=0 imm=0",
                     idex_valid, idex_inst, idex_pc, idex_imm, NOP_INST);
        end
        checks++;
        if (stall_cnt !== '0 || flush_cnt !== '0 || state !== 2'd0) begin
            errors++;
            $display("FAIL reset_ctrl got stall=%0d flush=%0d state=%0d exp 0 0 0", stall_cnt, flush_cnt, state);
        end
        reset = 1'b0;
        m_reset();
    endtask

    task automatic test_addi();
        do_reset();
        drive(1'b1, 32'hFFF00093, 32'h100, 1'b0, 1'b0);
        edge_step();
        checks++;
        if (idex_valid !== 1'b0) begin
            errors++; $display("FAIL addi_edgeN got valid=%0b exp 0", idex_valid);
        end
        drive(1'b0, NOP_INST, 32'h104, 1'b0, 1'b0);
        edge_step();
        checks++;
        if (idex_valid !== 1'b1 || idex_imm !== 32'hFFFFFFFF || idex_inst !== 32'hFFF00093 || idex_pc !== 32'h100) begin
            errors++;
            $display("FAIL addi_edgeN1 got v=%0b imm=%h inst=%h pc=%h exp 1 FFFFFFFF FFF00093 100",
                     idex_valid, idex_imm, idex_inst, idex_pc);
        end
    endtask

    task automatic test_imm_formats();
        logic [31:0] insts [3];
        logic [31:0] imms  [3];
        insts = '{32'hFE512E23, 32'hFE000CE3, 32'h123450B7};
        imms  = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000};
        do_reset();
        drive(1'b1, insts[0], 32'h200, 1'b0, 1'b0);
        edge_step();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) drive(1'b1, insts[i+1], 32'h204 + 32'(4*i), 1'b0, 1'b0);
            else       drive(1'b0, NOP_INST, 32'h0, 1'b0, 1'b0);
            edge_step();
            checks++;
            if (idex_valid !== 1'b1 || idex_imm !== imms[i]) begin
                errors++;
                $display("FAIL imm_fmt%0d got v=%0b imm=%h exp 1 %h", i, idex_valid, idex_imm, imms[i]);
            end
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 32'h00012283, 32'h400, 1'b0, 1'b0);   // lw x5,0(x2)
        edge_step();
        drive(1'b1, 32'h00728333, 32'h404, 1'b0, 1'b0);   // add x6,x5,x7
        #1;
        checks++;
        if (pc_write !== 1'b1) begin errors++; $display("FAIL lu_pcw_pre got %0b exp 1", pc_write); end
        edge_step();
        drive(1'b1, NOP_INST, 32'h408, 1'b0, 1'b0);
        #1;
        checks++;
        if (pc_write !== 1'b0) begin errors++; $display("FAIL lu_pcw_hz got %0b exp 0", pc_write); end
        edge_step();
        checks++;
        if (idex_valid !== 1'b0 || state !== 2'd1 || stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL lu_bubble got v=%0b state=%0d stall=%0d exp 0 1 1", idex_valid, state, stall_cnt);
        end
        drive(1'b1, NOP_INST, 32'h408, 1'b0, 1'b0);
        #1;
        checks++;
        if (pc_write !== 1'b1) begin errors++; $display("FAIL lu_pcw_stall got %0b exp 1", pc_write); end
        edge_step();
        checks++;
        if (idex_valid !== 1'b1 || idex_inst !== 32'h00728333 || idex_pc !== 32'h404 || state !== 2'd0) begin
            errors++;
            $display("FAIL lu_add got v=%0b inst=%h pc=%h state=%0d exp 1 00728333 404 0",
                     idex_valid, idex_inst, idex_pc, state);
        end
        // load to x0 never stalls
        drive(1'b1, 32'h00012003, 32'h40C, 1'b0, 1'b0);
        edge_step();
        drive(1'b1, 32'h00700333, 32'h410, 1'b0, 1'b0);
        edge_step();
        drive(1'b1, NOP_INST, 32'h414, 1'b0, 1'b0);
        #1;
        checks++;
        if (pc_write !== 1'b1) begin errors++; $display("FAIL lu_x0_pcw got %0b exp 1", pc_write); end
        edge_step();
        checks++;
        if (idex_valid !== 1'b1 || idex_inst !== 32'h00700333 || stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL lu_x0 got v=%0b inst=%h stall=%0d exp 1 00700333 1", idex_valid, idex_inst, stall_cnt);
        end
    endtask

    task automatic test_branch_flush();
        do_reset();
        drive(1'b1, 32'h00500093, 32'h300, 1'b0, 1'b0);
        edge_step();
        drive(1'b1, 32'h00700113, 32'h304, 1'b0, 1'b1);
        #1;
        checks++;
        if (pc_write !== 1'b1) begin errors++; $display("FAIL br_pcw got %0b exp 1", pc_write); end
        edge_step();
        checks++;
        if (idex_valid !== 1'b0 || state !== 2'd2 || flush_cnt !== 4'd1) begin
            errors++;
            $display("FAIL br_flush got v=%0b state=%0d flush=%0d exp 0 2 1", idex_valid, state, flush_cnt);
        end
        drive(1'b1, 32'h00900193, 32'h308, 1'b0, 1'b0);   // wrong path, must be dropped
        edge_step();
        checks++;
        if (idex_valid !== 1'b0 || state !== 2'd0) begin
            errors++; $display("FAIL br_resume got v=%0b state=%0d exp 0 0", idex_valid, state);
        end
        drive(1'b1, 32'h00A00213, 32'h30C, 1'b0, 1'b0);
        edge_step();
        checks++;
        if (idex_valid !== 1'b0) begin
            errors++; $display("FAIL br_discard got v=%0b inst=%h exp 0", idex_valid, idex_inst);
        end
        drive(1'b0, NOP_INST, 32'h0, 1'b0, 1'b0);
        edge_step();
        checks++;
        if (idex_valid !== 1'b1 || idex_inst !== 32'h00A00213 || idex_pc !== 32'h30C || idex_imm !== 32'hA) begin
            errors++;
            $display("FAIL br_target got v=%0b inst=%h pc=%h imm=%h exp 1 00A00213 30C A",
                     idex_valid, idex_inst, idex_pc, idex_imm);
        end
    endtask

    task automatic test_mem_busy();
        do_reset();
        drive(1'b1, 32'h00500093, 32'h500, 1'b0, 1'b0);
        edge_step();
        drive(1'b1, 32'h00700113, 32'h504, 1'b0, 1'b0);
        edge_step();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h00900193, 32'h508, 1'b1, k == 2);
            #1;
            checks++;
            if (pc_write !== 1'b0) begin errors++; $display("FAIL busy_pcw%0d got %0b exp 0", k, pc_write); end
            edge_step();
            checks++;
            if (idex_valid !== 1'b1 || idex_inst !== 32'h00500093 || idex_pc !== 32'h500 ||
                idex_imm !== 32'h5 || state !== 2'd0 || flush_cnt !== 4'd0 || stall_cnt !== 4'd0) begin
                errors++;
                $display("FAIL busy_hold%0d got v=%0b inst=%h pc=%h imm=%h st=%0d fl=%0d sc=%0d exp 1 00500093 500 5 0 0 0",
                         k, idex_valid, idex_inst, idex_pc, idex_imm, state, flush_cnt, stall_cnt);
            end
        end
        drive(1'b1, 32'h00900193, 32'h508, 1'b0, 1'b1);
        edge_step();
        checks++;
        if (state !== 2'd2 || flush_cnt !== 4'd1 || idex_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_release got st=%0d fl=%0d v=%0b exp 2 1 0", state, flush_cnt, idex_valid);
        end
    endtask

    task automatic test_saturation_reset();
        do_reset();
        for (int n = 1; n <= 20; n++) begin
            drive(1'b1, 32'h00012283, 32'h600, 1'b0, 1'b0);
            edge_step();
            drive(1'b1, 32'h00728333, 32'h604, 1'b0, 1'b0);
            edge_step();
            drive(1'b1, NOP_INST, 32'h608, 1'b0, 1'b0);
            edge_step();
            drive(1'b1, NOP_INST, 32'h608, 1'b0, 1'b0);
            edge_step();
            if (n == 3 || n == 15 || n == 20) begin
                checks++;
                if (stall_cnt !== CNT_W'((n > SAT) ? SAT : n)) begin
                    errors++; $display("FAIL sat_%0d got %0d exp %0d", n, stall_cnt, (n > SAT) ? SAT : n);
                end
            end
        end
        // asynchronous reset between edges
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (stall_cnt !== '0 || flush_cnt !== '0 || idex_valid !== 1'b0 || state !== 2'd0 || idex_inst !== NOP_INST) begin
            errors++;
            $display("FAIL async_reset got sc=%0d fl=%0d v=%0b st=%0d inst=%h exp 0 0 0 0 %h",
                     stall_cnt, flush_cnt, idex_valid, state, idex_inst, NOP_INST);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
    endtask

    task automatic test_random();
        bit v, busy, bt, pbusy, pbt;
        logic [31:0] pc;
        pbusy = 1'b0;
        pbt   = 1'b0;
        pc    = 32'h1000;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            busy = $urandom_range(0, 99) < 15;
            bt   = (m_idex.v && $urandom_range(0, 99) < 12) || (pbt && pbusy);
            v    = $urandom_range(0, 99) < 80;
            drive(v, gen_inst(), pc, busy, bt);
            pc += 4;
            #1;
            checks++;
            if (pc_write !== m_pcw(busy, bt)) begin
                errors++; $display("FAIL rnd_pcw c=%0d got %0b exp %0b", c, pc_write, m_pcw(busy, bt));
            end
            edge_step();
            pbusy = busy;
            pbt   = bt;
            checks++;
            if (idex_valid !== m_idex.v ||
                (m_idex.v && (idex_inst !== m_idex.inst || idex_pc !== m_idex.pc || idex_imm !== m_idex.imm))) begin
                errors++;
                $display("FAIL rnd_idex c=%0d got v=%0b inst=%h pc=%h imm=%h exp v=%0b inst=%h pc=%h imm=%h",
                         c, idex_valid, idex_inst, idex_pc, idex_imm, m_idex.v, m_idex.inst, m_idex.pc, m_idex.imm);
            end
            checks++;
            if (stall_cnt !== CNT_W'(m_stall) || flush_cnt !== CNT_W'(m_flush) || state !== 2'(m_mode)) begin
                errors++;
                $display("FAIL rnd_ctrl c=%0d got sc=%0d fl=%0d st=%0d exp %0d %0d %0d",
                         c, stall_cnt, flush_cnt, state, m_stall, m_flush, m_mode);
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_addi();
        test_imm_formats();
        test_load_use();
        test_branch_flush();
        test_mem_busy();
        test_saturation_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
